// File: rtl/key_event_scanner.sv
// Round-robin key scanner: visits one key per cycle and queues press/release
// events for every level change it finds, into a small event FIFO.
module key_event_scanner #(
  parameter int KEYS  = 61,
  parameter int DEPTH = 8,
  parameter int CW    = 6
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     en_i,
  input  logic [KEYS-1:0]          keys_i,
  output logic                     evt_valid_o,
  input  logic                     evt_ready_i,
  output logic [CW-1:0]            evt_code_o,
  output logic                     evt_press_o,
  output logic                     scan_wrap_o,
  output logic [$clog2(DEPTH):0]   fifo_cnt_o
);

  localparam int AW = $clog2(DEPTH);

  logic [KEYS-1:0] rep;
  logic [CW-1:0]   idx;
  logic [CW:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     cnt;
  logic            wrap;

  logic            key_lvl;
  logic            diff;
  logic            full;
  logic            last;
  logic            push;
  logic            pop;
  logic            advance;
  logic [CW:0]     head;

  // Full is judged on start-of-cycle occupancy, so a pop never frees room
  // for a push in the same cycle.
  always_comb begin
    key_lvl = keys_i[idx];
    diff    = key_lvl ^ rep[idx];
    full    = (cnt == (AW+1)'(DEPTH));
    last    = (idx == CW'(KEYS - 1));
    pop     = (cnt != '0) && evt_ready_i;
    push    = en_i && diff && !full;
    advance = en_i && (!diff || !full);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rep    <= '0;
      idx    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      wrap   <= 1'b0;
    end else begin
      if (push) begin
        rep[idx] <= key_lvl;
        wr_ptr   <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (advance) begin
        idx <= last ? '0 : idx + CW'(1);
      end
      wrap <= advance && last;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Event storage carries no reset; unused entries are masked at the output.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= {idx, key_lvl};
    end
  end

  always_comb begin
    head        = mem[rd_ptr];
    evt_valid_o = (cnt != '0);
    evt_code_o  = evt_valid_o ? head[CW:1] : '0;
    evt_press_o = evt_valid_o ? head[0] : 1'b0;
    scan_wrap_o = wrap;
    fifo_cnt_o  = cnt;
  end

endmodule

// File: tb/tb_key_event_scanner.sv
// Bench for key_event_scanner: directed scenarios plus random traffic, all
// checked cycle by cycle against a queue-based reference model.
module tb_key_event_scanner;
  localparam int KEYS  = 61;
  localparam int DEPTH = 8;
  localparam int CW    = 6;
  localparam int NW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            en = 1'b0;
  logic            ready = 1'b0;
  logic [KEYS-1:0] keys = '0;
  logic            valid;
  logic            press;
  logic            wrap;
  logic [CW-1:0]   code;
  logic [NW-1:0]   cnt;

  always #5 clk = ~clk;

  key_event_scanner #(.KEYS(KEYS), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .en_i        (en),
    .keys_i      (keys),
    .evt_valid_o (valid),
    .evt_ready_i (ready),
    .evt_code_o  (code),
    .evt_press_o (press),
    .scan_wrap_o (wrap),
    .fifo_cnt_o  (cnt)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: reported levels, scan position, event queue.
  bit m_rep [KEYS];
  int m_idx;
  int q_code [$];
  bit q_press [$];
  bit m_wrap;

  // Events and wrap pulses as actually seen on the DUT ports.
  int dut_code [$];
  bit dut_press [$];
  int dut_wraps;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    foreach (m_rep[i]) m_rep[i] = 1'b0;
    m_idx = 0;
    q_code.delete();
    q_press.delete();
    m_wrap = 1'b0;
  endtask

  task automatic clear_obs();
    dut_code.delete();
    dut_press.delete();
    dut_wraps = 0;
  endtask

  task automatic step();
    bit do_pop, full, do_push, adv, k;
    int pc;
    do_pop  = (q_code.size() != 0) && ready;
    full    = (q_code.size() == DEPTH);
    do_push = 1'b0;
    adv     = 1'b0;
    pc      = m_idx;
    k       = keys[m_idx];
    if (en) begin
      if (k != m_rep[m_idx]) begin
        if (!full) begin
          do_push = 1'b1;
          adv     = 1'b1;
        end
      end else begin
        adv = 1'b1;
      end
    end
    m_wrap = adv && (m_idx == KEYS - 1);
    if (adv) m_idx = (m_idx + 1) % KEYS;
    if (do_pop) begin
      void'(q_code.pop_front());
      void'(q_press.pop_front());
    end
    if (do_push) begin
      q_code.push_back(pc);
      q_press.push_back(k);
      m_rep[pc] = k;
    end
    if (valid === 1'b1 && ready) begin
      dut_code.push_back(int'(code));
      dut_press.push_back(press);
    end
    @(posedge clk);
    #1;
    if (wrap === 1'b1) dut_wraps++;
    chk("valid", valid, q_code.size() != 0);
    chk("cnt", cnt, q_code.size());
    chk("wrap", wrap, m_wrap);
    if (q_code.size() != 0) begin
      chk("code", code, q_code[0]);
      chk("press", press, q_press[0]);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Asserts reset mid-cycle, checks the asynchronous clear, then releases.
  task automatic apply_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", valid, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_code", code, 0);
    chk("rst_press", press, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Single held key after reset: press reported on the visit of index 5.
    keys = '0; keys[5] = 1'b1; en = 1'b1; ready = 1'b1;
    apply_reset();
    clear_obs();
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("first_evt_latency", valid, i == 6);
    end
    run(70);
    chk("one_press_count", dut_code.size(), 1);
    if (dut_code.size() == 1) begin
      chk("one_press_code", dut_code[0], 5);
      chk("one_press_type", dut_press[0], 1);
    end

    keys[5] = 1'b0;
    clear_obs();
    run(62);
    chk("release_count", dut_code.size(), 1);
    if (dut_code.size() == 1) begin
      chk("release_code", dut_code[0], 5);
      chk("release_type", dut_press[0], 0);
    end

    // Fill the FIFO with the consumer stalled, then exercise the full boundary.
    keys = '0; keys[11:0] = '1; ready = 1'b0;
    apply_reset();
    clear_obs();
    run(20);
    chk("fill_cnt", cnt, 8);
    chk("stall_no_wrap", dut_wraps, 0);
    ready = 1'b1; step();
    chk("full_pop_defers_push", cnt, 7);
    ready = 1'b0; step();
    chk("deferred_push", cnt, 8);
    ready = 1'b1; step();
    chk("pop_again", cnt, 7);
    step();
    chk("push_pop_at_7", cnt, 7);
    run(70);
    chk("drain_cnt", cnt, 0);
    chk("drain_count", dut_code.size(), 12);
    for (int i = 0; i < 12 && i < dut_code.size(); i++) begin
      chk("drain_order", dut_code[i], i);
      chk("drain_type", dut_press[i], 1);
    end

    // Scan paused: a held key must not be seen, and no wrap pulse.
    keys = '0; keys[60] = 1'b1; en = 1'b0; ready = 1'b1;
    apply_reset();
    clear_obs();
    run(70);
    chk("paused_events", dut_code.size(), 0);
    chk("paused_wraps", dut_wraps, 0);
    en = 1'b1;
    run(70);
    chk("key60_count", dut_code.size(), 1);
    if (dut_code.size() == 1) begin
      chk("key60_code", dut_code[0], 60);
      chk("key60_type", dut_press[0], 1);
    end
    chk("key60_wrap_seen", dut_wraps > 0, 1);

    // Reset while events are queued: everything pending is discarded.
    keys = '0; keys[4:0] = '1; ready = 1'b0;
    apply_reset();
    run(6);
    chk("queued5", cnt, 5);
    ready = 1'b1; step();
    chk("queued4", cnt, 4);
    apply_reset();
    clear_obs();
    run(12);
    chk("rereport_count", dut_code.size(), 5);
    for (int i = 0; i < 5 && i < dut_code.size(); i++) begin
      chk("rereport_code", dut_code[i], i);
      chk("rereport_type", dut_press[i], 1);
    end

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) begin
        int k;
        k = $urandom_range(KEYS - 1);
        keys[k] = ~keys[k];
      end
      if ($urandom_range(15) == 0) keys[$urandom_range(3)] = ~keys[$urandom_range(3)];
      ready = ($urandom_range(3) != 0);
      en    = ($urandom_range(7) != 0);
      if ($urandom_range(599) == 0) apply_reset();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
